// File: rtl/memory_access.sv
// memory_access: memory stage of the multi-cycle-handshake pipeline.
// Issues load/store requests on the data-memory bus, formats store data and
// byte strobes, extracts and extends load data, and stalls upstream through
// memory_ready_o until the access completes.
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN. When it is defined, misaligned
// half/word accesses skip the bus and flag M_misalign_o. When it is undefined,
// the low address bits that do not apply are ignored and M_misalign_o stays 0.
//
// Ports:
//   clk_i, rst                 clock, synchronous active-high reset
//   execute_vaild_i            ED_* inputs hold a valid instruction
//   write_back_allow_in_i      downstream register can accept this cycle
//   ED_mem_rd_i/ED_mem_wr_i    load / store
//   ED_mem_size_i              00 byte, 01 half, 1x word
//   ED_mem_unsigned_i          zero-extend loads
//   ED_valE_i, ED_valB_i       effective address, store data
//   dmem_*                     data-memory bus (request held until ack)
//   M_valM_o                   formatted load result
//   M_misalign_o               misaligned access flag
//   memory_ready_o             stage result available
module memory_access (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        execute_vaild_i,
  input  logic        write_back_allow_in_i,
  input  logic        ED_mem_rd_i,
  input  logic        ED_mem_wr_i,
  input  logic [1:0]  ED_mem_size_i,
  input  logic        ED_mem_unsigned_i,
  input  logic [31:0] ED_valE_i,
  input  logic [31:0] ED_valB_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] M_valM_o,
  output logic        M_misalign_o,
  output logic        memory_ready_o
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, valm_q, valm_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  off_q, off_d, size_q, size_d;
  logic        we_q, we_d, uns_q, uns_d, misalign_q, misalign_d;

  logic        mem_op, misaligned;
  logic [31:0] st_wdata, ld_data, ld_byte_sh, ld_half_sh;
  logic [3:0]  st_wstrb;

  assign mem_op = execute_vaild_i & (ED_mem_rd_i | ED_mem_wr_i);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = ((ED_mem_size_i == 2'b01) & ED_valE_i[0]) |
                      (ED_mem_size_i[1] & (|ED_valE_i[1:0]));
`else
  assign misaligned = 1'b0;
`endif

  // Store formatting from the live ED_* inputs; latched when the request is issued.
  always_comb begin
    st_wdata = ED_valB_i;
    st_wstrb = 4'b1111;
    case (ED_mem_size_i)
      2'b00: begin
        st_wdata = {4{ED_valB_i[7:0]}};
        st_wstrb = 4'b0001 << ED_valE_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{ED_valB_i[15:0]}};
        st_wstrb = 4'b0011 << {ED_valE_i[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Load formatting uses the latched byte offset, size and signedness.
  always_comb begin
    ld_byte_sh = dmem_rdata_i >> {off_q, 3'b000};
    ld_half_sh = dmem_rdata_i >> {off_q[1], 4'b0000};
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & ld_byte_sh[7]}}, ld_byte_sh[7:0]};
      2'b01:   ld_data = {{16{~uns_q & ld_half_sh[15]}}, ld_half_sh[15:0]};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    valm_d     = valm_q;
    misalign_d = misalign_q;
    case (state_q)
      StIdle: begin
        if (mem_op) begin
          if (misaligned) begin
            state_d    = StDone;
            valm_d     = '0;
            misalign_d = 1'b1;
          end else begin
            state_d = StReq;
            addr_d  = {ED_valE_i[31:2], 2'b00};
            off_d   = ED_valE_i[1:0];
            size_d  = ED_mem_size_i;
            uns_d   = ED_mem_unsigned_i;
            we_d    = ED_mem_wr_i;
            wdata_d = st_wdata;
            wstrb_d = ED_mem_wr_i ? st_wstrb : 4'b0000;
          end
        end
      end
      StReq: begin
        if (dmem_ack_i) begin
          state_d = StDone;
          valm_d  = we_q ? '0 : ld_data;
        end
      end
      StDone: begin
        if (write_back_allow_in_i) begin
          state_d    = StIdle;
          misalign_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      valm_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      valm_q     <= valm_d;
      misalign_q <= misalign_d;
    end
  end

  assign dmem_req_o     = (state_q == StReq);
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_wdata_o   = wdata_q;
  assign dmem_wstrb_o   = wstrb_q;
  assign M_valM_o       = valm_q;
  assign M_misalign_o   = misalign_q;
  assign memory_ready_o = ((state_q == StIdle) & ~mem_op) | (state_q == StDone);

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        execute_vaild_i = 1'b0;
  logic        write_back_allow_in_i = 1'b0;
  logic        ED_mem_rd_i = 1'b0;
  logic        ED_mem_wr_i = 1'b0;
  logic [1:0]  ED_mem_size_i = 2'b00;
  logic        ED_mem_unsigned_i = 1'b0;
  logic [31:0] ED_valE_i = '0;
  logic [31:0] ED_valB_i = '0;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i = 1'b0;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i = '0;
  logic [3:0]  dmem_wstrb_o;
  logic [31:0] M_valM_o;
  logic        M_misalign_o, memory_ready_o;

  int n_cmp = 0;
  int n_err = 0;

  memory_access dut (
    .clk_i                 (clk_i),
    .rst                   (rst),
    .execute_vaild_i       (execute_vaild_i),
    .write_back_allow_in_i (write_back_allow_in_i),
    .ED_mem_rd_i           (ED_mem_rd_i),
    .ED_mem_wr_i           (ED_mem_wr_i),
    .ED_mem_size_i         (ED_mem_size_i),
    .ED_mem_unsigned_i     (ED_mem_unsigned_i),
    .ED_valE_i             (ED_valE_i),
    .ED_valB_i             (ED_valB_i),
    .dmem_req_o            (dmem_req_o),
    .dmem_we_o             (dmem_we_o),
    .dmem_addr_o           (dmem_addr_o),
    .dmem_wdata_o          (dmem_wdata_o),
    .dmem_wstrb_o          (dmem_wstrb_o),
    .dmem_ack_i            (dmem_ack_i),
    .dmem_rdata_i          (dmem_rdata_i),
    .M_valM_o              (M_valM_o),
    .M_misalign_o          (M_misalign_o),
    .memory_ready_o        (memory_ready_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: bus image and load result from plain arithmetic.
  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] vb);
    if (sz == 2'd0) return (vb % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (vb % 65536) * 32'h0001_0001;
    return vb;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic wr, input logic [1:0] sz,
                                         input logic [31:0] a);
    int o = int'(a % 4);
    if (!wr) return 4'd0;
    if (sz == 2'd0) return 4'(1 << o);
    if (sz == 2'd1) return 4'(3 << ((o / 2) * 2));
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int o = int'(a % 4);
    if (sz == 2'd0) begin
      v = longint'((rd >> (8 * o)) % 256);
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = longint'((rd >> (16 * (o / 2))) % 65536);
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One complete memory op: bus checks each REQ cycle, result checks each DONE cycle.
  task automatic do_op(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] vb, input logic [31:0] rd,
                       input int ack_dly, input int wb_dly, input string nm);
    logic [31:0] e_addr, e_wd, e_m;
    logic [3:0]  e_st;
    e_addr = a - (a % 4);
    e_wd   = m_wdata(sz, vb);
    e_st   = m_wstrb(wr, sz, a);
    e_m    = wr ? 32'd0 : m_load(sz, uns, a, rd);
    execute_vaild_i = 1'b1; ED_mem_rd_i = ~wr; ED_mem_wr_i = wr;
    ED_mem_size_i = sz; ED_mem_unsigned_i = uns; ED_valE_i = a; ED_valB_i = vb;
    write_back_allow_in_i = 1'b0; dmem_ack_i = 1'b0;
    #1;
    n_cmp++;
    if (memory_ready_o !== 1'b0) begin
      n_err++; $display("FAIL %s idle_ready got %b exp 0", nm, memory_ready_o);
    end
    tick();
    for (int i = 0; i <= ack_dly; i++) begin
      n_cmp++;
      if (dmem_req_o !== 1'b1 || dmem_addr_o !== e_addr || dmem_we_o !== wr ||
          dmem_wstrb_o !== e_st || memory_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL %s req_cyc%0d got req=%b addr=%h we=%b st=%b rdy=%b exp 1 %h %b %b 0",
                 nm, i, dmem_req_o, dmem_addr_o, dmem_we_o, dmem_wstrb_o, memory_ready_o,
                 e_addr, wr, e_st);
      end
      if (wr) begin
        n_cmp++;
        if (dmem_wdata_o !== e_wd) begin
          n_err++; $display("FAIL %s wdata got %h exp %h", nm, dmem_wdata_o, e_wd);
        end
      end
      dmem_rdata_i = (i == ack_dly) ? rd : $urandom;
      dmem_ack_i   = (i == ack_dly);
      tick();
    end
    for (int i = 0; i <= wb_dly; i++) begin
      // Acks seen in DONE must be ignored.
      dmem_ack_i = (i == wb_dly) ? 1'b0 : 1'($urandom);
      dmem_rdata_i = $urandom;
      n_cmp++;
      if (memory_ready_o !== 1'b1 || dmem_req_o !== 1'b0 || M_valM_o !== e_m ||
          M_misalign_o !== 1'b0) begin
        n_err++;
        $display("FAIL %s done_cyc%0d got rdy=%b req=%b valM=%h mis=%b exp 1 0 %h 0",
                 nm, i, memory_ready_o, dmem_req_o, M_valM_o, M_misalign_o, e_m);
      end
      write_back_allow_in_i = (i == wb_dly);
      tick();
    end
    execute_vaild_i = 1'b0; write_back_allow_in_i = 1'b0; dmem_ack_i = 1'b0;
    #1;
    n_cmp++;
    if (memory_ready_o !== 1'b1 || dmem_req_o !== 1'b0 || M_valM_o !== e_m) begin
      n_err++;
      $display("FAIL %s after got rdy=%b req=%b valM=%h exp 1 0 %h",
               nm, memory_ready_o, dmem_req_o, M_valM_o, e_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (dmem_req_o !== 1'b0 || dmem_we_o !== 1'b0 || dmem_addr_o !== 32'd0 ||
        dmem_wdata_o !== 32'd0 || dmem_wstrb_o !== 4'd0 || M_valM_o !== 32'd0 ||
        M_misalign_o !== 1'b0 || memory_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset got req=%b we=%b addr=%h wd=%h st=%b valM=%h mis=%b rdy=%b exp all 0, rdy=1",
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o, M_valM_o,
               M_misalign_o, memory_ready_o);
    end
  endtask

  task automatic test_directed();
    do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, "lw_100");
    do_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, "lb_103");
    do_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 1, 0, "lbu_103");
    do_op(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234_ABCD, 32'h0, 5, 0, "sh_102");
    do_op(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 32'h8001_7FFF, 0, 3, "lh_done_hold");
  endtask

  task automatic test_nonmem();
    execute_vaild_i = 1'b1; ED_mem_rd_i = 1'b0; ED_mem_wr_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (memory_ready_o !== 1'b1 || dmem_req_o !== 1'b0) begin
        n_err++; $display("FAIL nonmem_%0d got rdy=%b req=%b exp 1 0", i, memory_ready_o, dmem_req_o);
      end
      tick();
      n_cmp++;
      if (dmem_req_o !== 1'b0) begin
        n_err++; $display("FAIL nonmem_req_%0d got %b exp 0", i, dmem_req_o);
      end
      execute_vaild_i = 1'b0; ED_mem_rd_i = 1'b1;
    end
    ED_mem_rd_i = 1'b0;
  endtask

  task automatic test_reset_in_req();
    execute_vaild_i = 1'b1; ED_mem_rd_i = 1'b1; ED_mem_wr_i = 1'b0;
    ED_mem_size_i = 2'd2; ED_valE_i = 32'h300;
    tick();
    n_cmp++;
    if (dmem_req_o !== 1'b1) begin
      n_err++; $display("FAIL rst_req_pre got req=%b exp 1", dmem_req_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; execute_vaild_i = 1'b0; ED_mem_rd_i = 1'b0;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
    #1;
    n_cmp++;
    if (dmem_req_o !== 1'b0 || memory_ready_o !== 1'b1) begin
      n_err++; $display("FAIL rst_req_post got req=%b rdy=%b exp 0 1", dmem_req_o, memory_ready_o);
    end
    tick();
    dmem_ack_i = 1'b0;
    n_cmp++;
    if (dmem_req_o !== 1'b0 || memory_ready_o !== 1'b1 || M_valM_o !== 32'd0) begin
      n_err++;
      $display("FAIL late_ack got req=%b rdy=%b valM=%h exp 0 1 0",
               dmem_req_o, memory_ready_o, M_valM_o);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
    execute_vaild_i = 1'b1; ED_mem_rd_i = 1'b1; ED_mem_wr_i = 1'b0;
    ED_mem_size_i = 2'd2; ED_valE_i = 32'h102; write_back_allow_in_i = 1'b1;
    tick();
    execute_vaild_i = 1'b0; ED_mem_rd_i = 1'b0;
    n_cmp++;
    if (dmem_req_o !== 1'b0 || M_misalign_o !== 1'b1 || memory_ready_o !== 1'b1 ||
        M_valM_o !== 32'd0) begin
      n_err++;
      $display("FAIL misalign got req=%b mis=%b rdy=%b valM=%h exp 0 1 1 0",
               dmem_req_o, M_misalign_o, memory_ready_o, M_valM_o);
    end
    tick();
    write_back_allow_in_i = 1'b0;
    n_cmp++;
    if (M_misalign_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      n_err++; $display("FAIL misalign_clear got mis=%b req=%b exp 0 0", M_misalign_o, dmem_req_o);
    end
`else
    do_op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'hCAFE_F00D, 0, 0, "lw_102_noalign");
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom);
      a  = $urandom;
`ifdef MEM_MISALIGN_CHECK_EN
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz[1]) a[1:0] = 2'b00;
`endif
      do_op(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "random");
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_nonmem();
    test_reset_in_req();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
